// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: byte-stream front end for a serial pattern detector.
// Accepts words over valid/ready, shifts them MSB-first onto ser_data,
// clears the detector across stream gaps, qualifies and counts matches,
// and raises a sticky interrupt when the count reaches a threshold.
//
// Handshake: a word transfers on a rising clk edge where s_valid and
// s_ready are both high. s_ready is offered only in LOAD, or in the last
// SHIFT cycle of a word, and only while en is high. The source must hold
// s_data stable while s_valid is high and s_ready is low.
//
// dbg_state encoding: 0 = OFF, 1 = LOAD, 2 = SHIFT.
module seq_det_ctrl #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_data,
  output logic              det_clr,
  input  logic              seq_detected,
  input  logic              cnt_clr,
  input  logic [CNT_W-1:0]  match_thresh,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
  // A window is complete once the bit being shifted now is the SEQ_LEN-th.
  localparam logic [FILL_W-1:0] FILL_QUAL = FILL_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FILL_W-1:0]  fill;
  logic               qual_q;
  logic               det_clr_q;
  logic               busy_q;
  logic [CNT_W-1:0]   match_cnt_q;
  logic               irq_q;

  logic               word_end;
  logic               xfer;
  logic [FILL_W-1:0]  fill_inc;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               irq_set;

  // Handshake decode: ready in LOAD or on the final bit of a word, gated by en.
  always_comb begin
    word_end = (state == ST_SHIFT) && (bit_cnt == '0);
    s_ready  = en && ((state == ST_LOAD) || word_end);
    xfer     = s_valid && s_ready;
    fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
  end

  // Stream FSM: load, shift MSB-first, chain words or drop to LOAD/OFF.
  // shreg is zeroed whenever SHIFT is left so ser_data reads 0 outside SHIFT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      shreg     <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      qual_q    <= 1'b0;
      det_clr_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      qual_q <= (state == ST_SHIFT) && (fill >= FILL_QUAL);
      case (state)
        ST_OFF: begin
          shreg     <= '0;
          fill      <= '0;
          det_clr_q <= 1'b1;
          busy_q    <= 1'b0;
          if (en) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          fill <= '0;
          if (xfer) begin
            shreg     <= s_data;
            bit_cnt   <= BIT_LAST;
            det_clr_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= ST_SHIFT;
          end else if (!en) begin
            state <= ST_OFF;
          end
        end
        ST_SHIFT: begin
          fill <= fill_inc;
          if (bit_cnt != '0) begin
            // Mid-word: always finish the word, en is only looked at the end.
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else if (xfer) begin
            // Back-to-back word: no gap bit, fill keeps running so
            // matches may straddle the word boundary.
            shreg   <= s_data;
            bit_cnt <= BIT_LAST;
          end else begin
            // Stream gap: clear the detector and restart window qualification.
            shreg     <= '0;
            fill      <= '0;
            det_clr_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= en ? ST_LOAD : ST_OFF;
          end
        end
        default: begin
          shreg     <= '0;
          fill      <= '0;
          det_clr_q <= 1'b1;
          busy_q    <= 1'b0;
          state     <= ST_OFF;
        end
      endcase
    end
  end

  // Next match count: clear wins over increment, increment saturates.
  always_comb begin
    cnt_inc = qual_q && seq_detected;
    cnt_nxt = match_cnt_q;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (cnt_inc && (match_cnt_q != CNT_MAX)) begin
      cnt_nxt = match_cnt_q + 1'b1;
    end
    irq_set = (match_thresh != '0) && (cnt_nxt != match_cnt_q) &&
              (cnt_nxt == match_thresh);
  end

  // Match counter and sticky interrupt; a new set beats a same-cycle irq_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      match_cnt_q <= cnt_nxt;
      irq_q       <= irq_set || (irq_q && !irq_clr);
    end
  end

  assign ser_data  = shreg[DATA_W-1];
  assign det_clr   = det_clr_q;
  assign busy      = busy_q;
  assign match_cnt = match_cnt_q;
  assign irq       = irq_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed bench for seq_det_ctrl. A behavioural 8-bit
// sliding-window detector looking for 0x99 sits on each DUT's serial side.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_seq_det_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        cnt_clr;
  logic [15:0] match_thresh;
  logic        irq_clr;

  logic        s_ready, ser_data, det_clr, seq_detected, irq, busy;
  logic [15:0] match_cnt;
  logic [1:0]  dbg_state;

  logic        s_ready_s, ser_data_s, det_clr_s, seq_detected_s, irq_s, busy_s;
  logic [1:0]  match_cnt_s;
  logic [1:0]  dbg_state_s;
  logic [1:0]  thresh_s;

  logic [7:0]  win;
  logic [7:0]  win_s;

  int checks;
  int errors;

  logic [7:0]  w;
  logic [15:0] s16;
  logic [23:0] s24;
  int          n;

  seq_det_ctrl #(.DATA_W(8), .SEQ_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ser_data(ser_data), .det_clr(det_clr),
    .seq_detected(seq_detected), .cnt_clr(cnt_clr),
    .match_thresh(match_thresh), .match_cnt(match_cnt), .irq(irq),
    .irq_clr(irq_clr), .busy(busy), .dbg_state(dbg_state)
  );

  seq_det_ctrl #(.DATA_W(8), .SEQ_LEN(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_s), .ser_data(ser_data_s), .det_clr(det_clr_s),
    .seq_detected(seq_detected_s), .cnt_clr(cnt_clr),
    .match_thresh(thresh_s), .match_cnt(match_cnt_s), .irq(irq_s),
    .irq_clr(irq_clr), .busy(busy_s), .dbg_state(dbg_state_s)
  );

  // Clock and tie-offs.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  assign thresh_s = 2'b00;

  // Detector models: synchronous clear, combinational match on the window.
  always @(posedge clk) begin
    if (det_clr) win <= 8'h00;
    else         win <= {win[6:0], ser_data};
    if (det_clr_s) win_s <= 8'h00;
    else           win_s <= {win_s[6:0], ser_data_s};
  end
  assign seq_detected   = (win == 8'h99);
  assign seq_detected_s = (win_s == 8'h99);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; checks follow #1 later.
  task automatic nc();
    @(negedge clk);
  endtask

  task automatic pulse_cnt_clr();
    nc(); cnt_clr = 1'b1; #1;
    nc(); cnt_clr = 1'b0; #1;
  endtask

  // Matches in 0x999999 end at bit positions 7,11,15,19,23 (start p=0,4,..16);
  // each becomes visible in match_cnt 10 cycles after the first word's handshake plus p.
  function automatic int exp_cnt3(input int i);
    int c;
    c = 0;
    for (int p = 0; p <= 16; p += 4) if (i >= p + 10) c++;
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    cnt_clr = 1'b0; irq_clr = 1'b0; match_thresh = 16'd0;

    // Reset held with en and s_valid high.
    repeat (3) nc();
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_det_clr", det_clr, 1'b1);
    chk("rst_ser_data", ser_data, 1'b0);
    chk("rst_match_cnt", match_cnt, 16'd0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    nc(); rst = 1'b1; #1;
    chk("rel_s_ready_0", s_ready, 1'b0);
    nc(); s_valid = 1'b0; #1;
    chk("rel_s_ready_1", s_ready, 1'b1);
    chk("rel_state_load", dbg_state, 2'd1);

    // Single word 0x99: one match, count visible at t+10.
    w = 8'h99;
    nc(); s_data = w; s_valid = 1'b1; #1;
    chk("single_hs", s_ready, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      nc(); s_valid = 1'b0; #1;
      if (i <= 8) begin
        chk("single_ser", ser_data, w[3'(8 - i)]);
        chk("single_det_clr", det_clr, 1'b0);
        chk("single_busy", busy, 1'b1);
        chk("single_s_ready", s_ready, (i == 8) ? 1'b1 : 1'b0);
      end
      if (i == 9) begin
        chk("single_cnt_t9", match_cnt, 16'd0);
        chk("single_det_clr_load", det_clr, 1'b1);
      end
      if (i == 10) chk("single_cnt_t10", match_cnt, 16'd1);
    end

    // Back-to-back 0x0C, 0xC8: match only across the word boundary.
    pulse_cnt_clr();
    chk("b2b_cnt_cleared", match_cnt, 16'd0);
    s16 = 16'h0CC8;
    nc(); s_data = 8'h0C; s_valid = 1'b1; #1;
    chk("b2b_hs0", s_ready, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      nc();
      if (i == 1) s_data = 8'hC8;
      if (i == 9) s_valid = 1'b0;
      #1;
      if (i <= 16) begin
        chk("b2b_ser", ser_data, s16[4'(16 - i)]);
        chk("b2b_det_clr", det_clr, 1'b0);
        chk("b2b_s_ready", s_ready, (i == 8 || i == 16) ? 1'b1 : 1'b0);
      end
      if (i == 14) chk("b2b_cnt_t14", match_cnt, 16'd0);
      if (i == 15) chk("b2b_cnt_t15", match_cnt, 16'd1);
      if (i == 18) chk("b2b_cnt_end", match_cnt, 16'd1);
    end

    // Gap between 0x0C and 0xC8 clears the detector: no match.
    pulse_cnt_clr();
    nc(); s_data = 8'h0C; s_valid = 1'b1; #1;
    chk("gap_hs0", s_ready, 1'b1);
    for (int i = 1; i <= 23; i++) begin
      nc();
      s_valid = (i == 12) ? 1'b1 : 1'b0;
      if (i == 12) s_data = 8'hC8;
      #1;
      if (i >= 9 && i <= 11) begin
        chk("gap_det_clr", det_clr, 1'b1);
        chk("gap_state_load", dbg_state, 2'd1);
      end
      if (i == 12) chk("gap_hs1", s_ready, 1'b1);
      if (i == 13) chk("gap_shift_det_clr", det_clr, 1'b0);
      if (i == 23) chk("gap_cnt", match_cnt, 16'd0);
    end

    // Threshold 3 over three back-to-back 0x99 words; irq_clr at t+19.
    match_thresh = 16'd3;
    pulse_cnt_clr();
    s24 = 24'h999999;
    nc(); s_data = 8'h99; s_valid = 1'b1; #1;
    chk("thr_hs0", s_ready, 1'b1);
    for (int i = 1; i <= 27; i++) begin
      nc();
      s_valid = (i <= 16) ? 1'b1 : 1'b0;
      irq_clr = (i == 19) ? 1'b1 : 1'b0;
      #1;
      n = exp_cnt3(i);
      if (i <= 24) chk("thr_ser", ser_data, s24[5'(24 - i)]);
      chk("thr_cnt", match_cnt, 16'(n));
      chk("thr_irq", irq, (i == 18 || i == 19) ? 1'b1 : 1'b0);
      chk("sat_cnt", match_cnt_s, (n > 3) ? 2'd3 : 2'(n));
    end
    irq_clr = 1'b0;

    // cnt_clr in the same cycle as a counted match leaves 0.
    nc(); s_data = 8'h99; s_valid = 1'b1; #1;
    chk("clr_hs", s_ready, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      nc(); s_valid = 1'b0; cnt_clr = (i == 9) ? 1'b1 : 1'b0; #1;
      if (i == 9) begin
        chk("clr_cnt_before", match_cnt, 16'd5);
        chk("clr_seq_det", seq_detected, 1'b1);
      end
      if (i >= 10) begin
        chk("clr_cnt_after", match_cnt, 16'd0);
        chk("clr_sat_after", match_cnt_s, 2'd0);
        chk("clr_irq", irq, 1'b0);
      end
    end
    match_thresh = 16'd0;

    // en dropped after 3 bits: word completes, one match, then OFF.
    w = 8'h99;
    nc(); s_data = w; s_valid = 1'b1; #1;
    chk("endrop_hs", s_ready, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      nc();
      en = (i < 4 || i >= 11) ? 1'b1 : 1'b0;
      s_valid = (i < 12) ? 1'b1 : 1'b0;
      #1;
      if (i <= 8) begin
        chk("endrop_ser", ser_data, w[3'(8 - i)]);
        chk("endrop_busy", busy, 1'b1);
        chk("endrop_s_ready", s_ready, 1'b0);
      end
      if (i == 9) begin
        chk("endrop_state_off", dbg_state, 2'd0);
        chk("endrop_det_clr", det_clr, 1'b1);
        chk("endrop_s_ready_off", s_ready, 1'b0);
        chk("endrop_busy_off", busy, 1'b0);
      end
      if (i == 10) chk("endrop_cnt", match_cnt, 16'd1);
      if (i == 11) chk("endrop_reen_off", s_ready, 1'b0);
      if (i == 12) begin
        chk("endrop_reen_load", dbg_state, 2'd1);
        chk("endrop_reen_rdy", s_ready, 1'b1);
      end
    end

    // Asynchronous reset mid-word discards the word immediately.
    nc(); s_data = 8'hFF; s_valid = 1'b1; #1;
    chk("mrst_hs", s_ready, 1'b1);
    nc(); s_valid = 1'b0;
    nc();
    nc(); #1;
    chk("mrst_pre_ser", ser_data, 1'b1);
    #1; rst = 1'b0; #1;
    chk("mrst_ser", ser_data, 1'b0);
    chk("mrst_det_clr", det_clr, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_s_ready", s_ready, 1'b0);
    chk("mrst_cnt", match_cnt, 16'd0);
    chk("mrst_state", dbg_state, 2'd0);
    nc(); rst = 1'b1; #1;
    chk("mrst_rel_rdy0", s_ready, 1'b0);
    nc(); #1;
    chk("mrst_rel_rdy1", s_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
